// File: rtl/adv7393_pkg.sv
// adv7393_pkg: shared FSM type, AXI constants and helpers for the ADV7393 frame fetcher.
package adv7393_pkg;
  typedef enum logic [2:0] {IDLE, ARM, CHECK, ISSUE, DRAIN} fetch_state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  function automatic logic [2:0] arsize_f(input int dwidth);
    return 3'($clog2(dwidth / 8));
  endfunction
endpackage

// File: rtl/adv7393_fetch_tracker.sv
// adv7393_fetch_tracker: outstanding-burst and FIFO-reservation accounting, plus end-of-line marking.
module adv7393_fetch_tracker #(
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_AW = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             ar_hs,
  input  logic             beat,
  input  logic             beat_last,
  input  logic [7:0]       bursts_per_line,
  input  logic [FIFO_AW:0] fifo_space,
  output logic             can_issue,
  output logic             eol,
  output logic             empty
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int RW = FIFO_AW + 1;
  logic [OW-1:0] outstanding;
  logic [RW-1:0] reserved;
  logic [7:0] done;
  // Completed bursts are counted apart from the issue side so eol follows R order.
  assign eol = beat_last && done == bursts_per_line - 8'd1;
  assign empty = outstanding == '0;
  assign can_issue = (RW+1)'(fifo_space) >= (RW+1)'(reserved) + (RW+1)'(BURST_LEN)
                     && outstanding < OW'(MAX_OUTSTANDING);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      outstanding <= '0;
      reserved <= '0;
      done <= '0;
    end else begin
      outstanding <= outstanding + OW'(ar_hs) - OW'(beat_last);
      reserved <= reserved + (ar_hs ? RW'(BURST_LEN) : '0) - RW'(beat);
      done <= init ? '0 : !beat_last ? done : eol ? '0 : done + 8'd1;
    end
endmodule

// File: rtl/adv7393_frame_fetch.sv
// adv7393_frame_fetch: schedules AXI4 read bursts for one video frame and forwards R beats to the pixel FIFO.
module adv7393_frame_fetch import adv7393_pkg::*; #(
  parameter int M_AXI_DWIDTH = 64,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_AW = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    frame_start,
  input  logic [31:0]             cfg_base,
  input  logic [15:0]             cfg_stride,
  input  logic [7:0]              cfg_bursts_per_line,
  input  logic [10:0]             cfg_lines,
  input  logic [FIFO_AW:0]        fifo_space,
  output logic [31:0]             m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arregion,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [M_AXI_DWIDTH-1:0] m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [M_AXI_DWIDTH-1:0] fifo_wdata,
  output logic                    fifo_we,
  output logic                    fifo_eol,
  output logic                    busy,
  output logic                    err_resp,
  output logic                    err_overrun,
  input  logic                    err_clr
);
  localparam int BURST_BYTES = BURST_LEN * M_AXI_DWIDTH / 8;
  fetch_state_t state, state_nx;
  logic [15:0] stride;
  logic [7:0] bpl, burst;
  logic [10:0] lines, line;
  logic [31:0] line_addr;
  logic ar_hs, beat, beat_last, can_issue, eol, empty, line_end, last_burst;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign beat = m_axi_rvalid & m_axi_rready;
  assign beat_last = beat & m_axi_rlast;
  assign line_end = burst == bpl - 8'd1;
  assign last_burst = line_end && line == lines - 11'd1;
  assign m_axi_araddr = line_addr + 32'(burst) * 32'(BURST_BYTES);
  assign m_axi_arlen = 8'(BURST_LEN - 1);
  assign m_axi_arsize = arsize_f(M_AXI_DWIDTH);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arlock = 1'b0;
  assign m_axi_arprot = 3'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_arqos = 4'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = frame_start && enable ? ARM : IDLE;
      ARM:     state_nx = CHECK;
      CHECK:   state_nx = !enable ? DRAIN : can_issue ? ISSUE : CHECK;
      ISSUE:   state_nx = !m_axi_arready ? ISSUE : last_burst || !enable ? DRAIN : CHECK;
      DRAIN:   state_nx = empty ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    m_axi_arvalid = state == ISSUE;
    busy = state != IDLE;
  end
  // Shadow copies make mid-frame cfg changes take effect only on the next frame.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stride <= '0;
      bpl <= '0;
      lines <= '0;
      line <= '0;
      burst <= '0;
      line_addr <= '0;
    end else if (state == ARM) begin
      stride <= cfg_stride;
      bpl <= cfg_bursts_per_line == 8'd0 ? 8'd1 : cfg_bursts_per_line;
      lines <= cfg_lines == 11'd0 ? 11'd1 : cfg_lines;
      line <= '0;
      burst <= '0;
      line_addr <= cfg_base;
    end else if (ar_hs) begin
      burst <= line_end ? 8'd0 : burst + 8'd1;
      if (line_end) begin
        line <= line + 11'd1;
        line_addr <= line_addr + 32'(stride);
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      m_axi_rready <= 1'b0;
      fifo_we <= 1'b0;
      fifo_eol <= 1'b0;
      fifo_wdata <= '0;
      err_resp <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      m_axi_rready <= 1'b1;
      fifo_we <= beat;
      fifo_eol <= eol;
      if (beat) fifo_wdata <= m_axi_rdata;
      err_resp <= (beat && m_axi_rresp != AXI_RESP_OKAY) || (err_resp && !err_clr);
      err_overrun <= (frame_start && state != IDLE) || (err_overrun && !err_clr);
    end
  adv7393_fetch_tracker #(
    .BURST_LEN(BURST_LEN),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .FIFO_AW(FIFO_AW)
  ) u_tracker (
    .clk(clk),
    .reset(reset),
    .init(state == ARM),
    .ar_hs(ar_hs),
    .beat(beat),
    .beat_last(beat_last),
    .bursts_per_line(bpl),
    .fifo_space(fifo_space),
    .can_issue(can_issue),
    .eol(eol),
    .empty(empty)
  );
endmodule

// File: tb/tb_adv7393_frame_fetch.sv
// tb_adv7393_frame_fetch: table-driven frame vectors plus directed corner sequences for the frame fetcher.
module tb_adv7393_frame_fetch;
  localparam int BL = 16;
  logic clk = 0, reset = 1, enable = 0, frame_start = 0, err_clr = 0;
  logic [31:0] cfg_base = 0;
  logic [15:0] cfg_stride = 0;
  logic [7:0] cfg_bpl = 0;
  logic [10:0] cfg_lines = 0;
  logic [10:0] fifo_space = 11'd1023;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, rresp = 0;
  logic arlock, arvalid, arready = 1, rlast = 0, rvalid = 0, rready;
  logic [3:0] arcache, arregion, arqos;
  logic [63:0] rdata = 0, fifo_wdata;
  logic fifo_we, fifo_eol, busy, err_resp, err_overrun;

  typedef struct {
    logic [31:0] base;
    logic [15:0] stride;
    logic [7:0]  bpl;
    logic [10:0] lines;
    int          ars;
    int          beats;
    int          eols;
    logic [31:0] last_addr;
  } vec_t;
  vec_t vecs[4];

  int total = 0, bad = 0;
  int ar_cnt, we_cnt, eol_cnt, eol_bad, data_bad, pend, bidx, beat_g, bad_beat = -1, eol_period = 32;
  bit r_en = 1;
  logic [31:0] ar_log[$];
  logic [63:0] dq[$];

  adv7393_frame_fetch dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_bursts_per_line(cfg_bpl),
    .cfg_lines(cfg_lines), .fifo_space(fifo_space),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arregion(arregion), .m_axi_arqos(arqos),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .fifo_wdata(fifo_wdata), .fifo_we(fifo_we), .fifo_eol(fifo_eol),
    .busy(busy), .err_resp(err_resp), .err_overrun(err_overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic clear_log();
    ar_cnt = 0; we_cnt = 0; eol_cnt = 0; eol_bad = 0; data_bad = 0;
    pend = 0; bidx = 0; beat_g = 0;
    ar_log.delete();
    dq.delete();
  endtask

  // One clock: log the AR handshake, score the FIFO write, then present the next R beat.
  task automatic cycle();
    if (arvalid && arready) begin
      ar_cnt++;
      ar_log.push_back(araddr);
      pend++;
    end
    @(posedge clk);
    #1;
    if (fifo_we) begin
      we_cnt++;
      if (dq.size() == 0) data_bad++;
      else if (fifo_wdata !== dq.pop_front()) data_bad++;
      if (fifo_eol) begin
        eol_cnt++;
        if (we_cnt % eol_period != 0) eol_bad++;
      end
    end else if (fifo_eol) eol_bad++;
    frame_start = 0;
    err_clr = 0;
    if (r_en && pend > 0) begin
      rvalid = 1;
      rlast = bidx == BL - 1;
      rresp = beat_g == bad_beat ? 2'b10 : 2'b00;
      rdata = {32'hC0DE_0000, 32'(beat_g)};
      dq.push_back(rdata);
      beat_g++;
      bidx = rlast ? 0 : bidx + 1;
      if (rlast) pend--;
    end else begin
      rvalid = 0;
      rlast = 0;
      rresp = 0;
    end
  endtask

  task automatic start(input logic [31:0] b, input logic [15:0] s, input logic [7:0] n, input logic [10:0] l);
    cfg_base = b; cfg_stride = s; cfg_bpl = n; cfg_lines = l;
    enable = 1;
    frame_start = 1;
    cycle();
    cycle();
    cfg_base = 32'hDEAD_0000; cfg_stride = 16'h1234; cfg_bpl = 8'd7; cfg_lines = 11'd9;
  endtask

  task automatic finish_frame(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      cycle();
      n++;
    end
    check("frame_timeout", busy, 0);
  endtask

  initial begin
    logic [31:0] a0, exp_a, last_a;
    int stable_bad, addr_bad, bpl_n, n;
    vecs[0] = '{32'h1000_0000, 16'h0800, 8'd2, 11'd3, 6, 96, 3, 32'h1000_1080};
    vecs[1] = '{32'h2000_0000, 16'h0100, 8'd0, 11'd0, 1, 16, 1, 32'h2000_0000};
    vecs[2] = '{32'hFFFF_F000, 16'h0800, 8'd1, 11'd3, 3, 48, 3, 32'h0000_0000};
    vecs[3] = '{32'h0000_4000, 16'h0400, 8'd3, 11'd2, 6, 96, 2, 32'h0000_4500};
    clear_log();
    #12;
    check("rst_arvalid", arvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_we", fifo_we, 0);
    check("rst_fifo_eol", fifo_eol, 0);
    check("rst_wdata", fifo_wdata, 0);
    check("rst_rready", rready, 0);
    check("rst_errs", {err_resp, err_overrun}, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 15);
    check("rst_arsize", arsize, 3);
    check("rst_arburst", arburst, 1);
    check("rst_arcache", arcache, 3);
    check("rst_ar_zero", {arlock, arprot, arregion, arqos}, 0);
    reset = 0;
    cycle();
    check("rready_on", rready, 1);

    enable = 0;
    frame_start = 1;
    cycle();
    cycle();
    check("disabled_start_busy", busy, 0);
    check("disabled_start_err", err_overrun, 0);

    for (int i = 0; i < 4; i++) begin
      clear_log();
      r_en = 1; arready = 1; fifo_space = 11'd1023;
      bpl_n = vecs[i].bpl == 0 ? 1 : int'(vecs[i].bpl);
      eol_period = bpl_n * BL;
      start(vecs[i].base, vecs[i].stride, vecs[i].bpl, vecs[i].lines);
      finish_frame(3000);
      last_a = ar_log.size() > 0 ? ar_log[ar_log.size() - 1] : 32'hxxxx_xxxx;
      addr_bad = 0;
      for (int k = 0; k < ar_log.size(); k++) begin
        exp_a = vecs[i].base + 32'(k / bpl_n) * 32'(vecs[i].stride) + 32'(k % bpl_n) * 32'd128;
        if (ar_log[k] !== exp_a) addr_bad++;
      end
      check($sformatf("v%0d_ars", i), ar_cnt, vecs[i].ars);
      check($sformatf("v%0d_last_addr", i), last_a, vecs[i].last_addr);
      check($sformatf("v%0d_addr_seq", i), addr_bad, 0);
      check($sformatf("v%0d_beats", i), we_cnt, vecs[i].beats);
      check($sformatf("v%0d_eols", i), eol_cnt, vecs[i].eols);
      check($sformatf("v%0d_eol_pos", i), eol_bad, 0);
      check($sformatf("v%0d_data", i), data_bad, 0);
      check($sformatf("v%0d_err_resp", i), err_resp, 0);
    end

    clear_log();
    eol_period = 32;
    r_en = 0; fifo_space = 11'd20;
    start(32'h1000_0000, 16'h0800, 8'd2, 11'd3);
    repeat (30) cycle();
    check("bp_one_ar", ar_cnt, 1);
    fifo_space = 11'd40;
    repeat (30) cycle();
    check("bp_two_ar", ar_cnt, 2);
    fifo_space = 11'd1023; r_en = 1;
    finish_frame(3000);
    check("bp_ars", ar_cnt, 6);
    check("bp_beats", we_cnt, 96);
    check("bp_eols", eol_cnt, 3);

    clear_log();
    r_en = 0;
    start(32'h1000_0000, 16'h0800, 8'd2, 11'd3);
    repeat (40) cycle();
    check("cap_ars", ar_cnt, 4);
    check("cap_arvalid_low", arvalid, 0);
    r_en = 1;
    repeat (16) cycle();
    check("cap_hold_until_rlast", ar_cnt, 4);
    finish_frame(3000);
    check("cap_total_ars", ar_cnt, 6);
    check("cap_beats", we_cnt, 96);

    clear_log();
    arready = 0;
    start(32'h1000_0000, 16'h0800, 8'd2, 11'd3);
    n = 0;
    while (!arvalid && n < 20) begin
      cycle();
      n++;
    end
    check("stall_arvalid", arvalid, 1);
    a0 = araddr;
    stable_bad = 0;
    repeat (10) begin
      cycle();
      if (!arvalid || araddr !== a0) stable_bad++;
    end
    check("stall_stable", stable_bad, 0);
    check("stall_no_hs", ar_cnt, 0);
    check("stall_addr", a0, 32'h1000_0000);
    arready = 1;
    cycle();
    check("stall_hs_11th", ar_cnt, 1);
    finish_frame(3000);
    check("stall_ars", ar_cnt, 6);
    check("stall_beats", we_cnt, 96);

    clear_log();
    bad_beat = 5;
    start(32'h1000_0000, 16'h0800, 8'd2, 11'd3);
    repeat (10) cycle();
    frame_start = 1;
    cycle();
    check("overrun_set", err_overrun, 1);
    repeat (5) cycle();
    check("resp_set", err_resp, 1);
    err_clr = 1;
    frame_start = 1;
    cycle();
    check("clr_vs_set_overrun", err_overrun, 1);
    check("clr_resp", err_resp, 0);
    finish_frame(3000);
    last_a = ar_log.size() > 0 ? ar_log[ar_log.size() - 1] : 32'hxxxx_xxxx;
    check("err_ars", ar_cnt, 6);
    check("err_last_addr", last_a, 32'h1000_1080);
    check("err_beats", we_cnt, 96);
    check("err_data", data_bad, 0);
    err_clr = 1;
    cycle();
    check("clr_both", {err_resp, err_overrun}, 0);
    bad_beat = -1;

    clear_log();
    start(32'h1000_0000, 16'h0800, 8'd2, 11'd3);
    n = 0;
    while (ar_cnt < 3 && n < 100) begin
      cycle();
      n++;
    end
    enable = 0;
    finish_frame(3000);
    check("drop_ars", ar_cnt, 3);
    check("drop_beats", we_cnt, 48);
    check("drop_eols", eol_cnt, 1);
    check("drop_data", data_bad, 0);

    clear_log();
    start(32'h1000_0000, 16'h0800, 8'd2, 11'd3);
    repeat (12) cycle();
    check("rst_mid_busy_before", busy, 1);
    #2 reset = 1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_arvalid", arvalid, 0);
    check("rst_mid_we", fifo_we, 0);
    check("rst_mid_rready", rready, 0);
    check("rst_mid_araddr", araddr, 0);
    check("rst_mid_wdata", fifo_wdata, 0);
    rvalid = 0; rlast = 0; rresp = 0;
    clear_log();
    #10 reset = 0;
    cycle();
    check("rst_mid_idle_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
